// File: rtl/req_onehot_arbiter.sv
// req_onehot_arbiter: synchronises four asynchronous request lines, turns
// rising edges into pending events and grants them one at a time, round-robin,
// as a one-hot word with a valid/ready handshake. Events that arrive while the
// same line is still pending are counted in a saturating drop counter.
module req_onehot_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_in,
  output logic [3:0]       onehot_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SW = SYNC_STAGES * 4;
  localparam logic [CNT_W+2:0] DROP_MAX = {3'b000, {CNT_W{1'b1}}};

  typedef enum logic {IDLE, PRESENT} state_t;

  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("req_onehot_arbiter: SYNC_STAGES must be in 1..3");
  end

  // Stage k of the synchroniser lives in sync_q[4k+3:4k]; the oldest stage is on top.
  logic [SW-1:0]      sync_q;
  logic [3:0]         s;
  logic [3:0]         prev;
  logic [3:0]         rise;
  logic [3:0]         clr;
  logic [3:0]         drop_vec;
  logic [2:0]         drop_num;
  logic [CNT_W+2:0]   drop_sum;

  state_t             state, state_n;
  logic [1:0]         ptr, ptr_n;
  logic [1:0]         gnt_idx, gnt_idx_n;
  logic [3:0]         onehot_n;
  logic               valid_n;
  logic [3:0]         rot;
  logic [1:0]         off;
  logic [1:0]         sel;

  assign s    = sync_q[SW-1 -: 4];
  assign rise = s & ~prev;

  // Lost events: a new edge on a line whose previous event is still pending and not being cleared.
  always_comb begin
    drop_vec = rise & pending & ~clr;
    drop_num = {2'b00, drop_vec[0]} + {2'b00, drop_vec[1]}
             + {2'b00, drop_vec[2]} + {2'b00, drop_vec[3]};
    drop_sum = {3'b000, drop_cnt} + {{CNT_W{1'b0}}, drop_num};
  end

  // Synchroniser, edge history, pending events and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      prev     <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      sync_q   <= SW'({sync_q, req_in});
      prev     <= s;
      pending  <= rise | (pending & ~clr);
      if (drop_sum > DROP_MAX) drop_cnt <= '1;
      else                     drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

  // Round-robin pick: rotate pending so bit ptr lands at position 0, take the lowest set bit.
  always_comb begin
    rot = 4'({pending, pending} >> ptr);
    off = '0;
    if      (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    sel = ptr + off;
  end

  // Grant FSM next state, registered-output next values and handshake clear.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_idx_n = gnt_idx;
    onehot_n  = onehot_out;
    valid_n   = out_valid;
    clr       = '0;
    unique case (state)
      IDLE: begin
        onehot_n = '0;
        valid_n  = 1'b0;
        if (pending != 4'b0000) begin
          gnt_idx_n = sel;
          onehot_n  = 4'b0001 << sel;
          valid_n   = 1'b1;
          state_n   = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          clr      = onehot_out;
          ptr_n    = gnt_idx + 2'd1;
          onehot_n = '0;
          valid_n  = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant FSM state, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      onehot_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gnt_idx    <= gnt_idx_n;
      onehot_out <= onehot_n;
      out_valid  <= valid_n;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Self-checking bench for req_onehot_arbiter: directed scenarios with inline
// checks plus a grant scoreboard that compares every accepted grant.
module tb_req_onehot_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] onehot_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  logic       rst2;
  logic [3:0] req2;
  logic [3:0] onehot2;
  logic       valid2;
  logic       ready2;
  logic [3:0] pending2;
  logic [1:0] drop2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;

  req_onehot_arbiter #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .onehot_out(onehot_out),
    .out_valid(out_valid), .out_ready(out_ready), .pending(pending), .drop_cnt(drop_cnt)
  );

  req_onehot_arbiter #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .req_in(req2), .onehot_out(onehot2),
    .out_valid(valid2), .out_ready(ready2), .pending(pending2), .drop_cnt(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted grant must match the next expected one-hot word.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(onehot_out)) $display("FAIL onehot_invariant: got %b want zero or one bit set", onehot_out);
    else n_pass++;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL grant_sb: got %b want no grant (queue empty)", onehot_out);
      end else begin
        exp_g = exp_q.pop_front();
        if (onehot_out !== exp_g) $display("FAIL grant_sb: got %b want %b", onehot_out, exp_g);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = '0; out_ready = 1'b0;
    tick(3);
    n_checks++;
    if ({onehot_out, out_valid, pending, drop_cnt} !== 17'd0)
      $display("FAIL rst_hold: got oh=%b v=%b p=%b d=%0d want all 0", onehot_out, out_valid, pending, drop_cnt);
    else n_pass++;
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({onehot_out, out_valid, pending, drop_cnt} !== 17'd0)
      $display("FAIL rst_release: got oh=%b v=%b p=%b d=%0d want all 0", onehot_out, out_valid, pending, drop_cnt);
    else n_pass++;
    n_checks++;
    if (dut.ptr !== 2'd0) $display("FAIL rst_ptr: got %0d want 0", dut.ptr);
    else n_pass++;
    req_in = 4'b0001; exp_q.push_back(4'b0001);
    tick(3);
    n_checks++;
    if (pending !== 4'b0001 || out_valid !== 1'b0)
      $display("FAIL lat_pending: got p=%b v=%b want p=0001 v=0", pending, out_valid);
    else n_pass++;
    tick(1);
    n_checks++;
    if (out_valid !== 1'b1 || onehot_out !== 4'b0001)
      $display("FAIL lat_valid: got v=%b oh=%b want v=1 oh=0001", out_valid, onehot_out);
    else n_pass++;
    out_ready = 1'b1;
    tick(1);
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000)
      $display("FAIL lat_accept: got v=%b p=%b want v=0 p=0000", out_valid, pending);
    else n_pass++;
    out_ready = 1'b0; req_in = '0;
    tick(4);
  endtask

  task automatic test_all_four();
    do_reset();
    out_ready = 1'b1; req_in = 4'b1111;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    tick(3);
    for (int k = 4; k <= 11; k++) begin
      tick(1);
      n_checks++;
      if (out_valid !== ((k % 2) == 0)) $display("FAIL rr_cadence: edge %0d got v=%b want %b", k, out_valid, (k % 2) == 0);
      else n_pass++;
    end
    tick(2);
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000 || exp_q.size() != 0)
      $display("FAIL rr_drain: got v=%b p=%b left=%0d want v=0 p=0000 left=0", out_valid, pending, exp_q.size());
    else n_pass++;
    out_ready = 1'b0; req_in = '0;
    tick(4);
  endtask

  task automatic test_wrap();
    req_in = 4'b0010; exp_q.push_back(4'b0010); out_ready = 1'b1;
    tick(6);
    n_checks++;
    if (dut.ptr !== 2'd2) $display("FAIL wrap_ptr: got %0d want 2", dut.ptr);
    else n_pass++;
    req_in = '0;
    tick(4);
    out_ready = 1'b0; req_in = 4'b0011;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    tick(3);
    n_checks++;
    if (pending !== 4'b0011) $display("FAIL wrap_pending: got %b want 0011", pending);
    else n_pass++;
    tick(1);
    n_checks++;
    if (onehot_out !== 4'b0001 || out_valid !== 1'b1) $display("FAIL wrap_first: got oh=%b v=%b want 0001 1", onehot_out, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    tick(4);
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000 || exp_q.size() != 0)
      $display("FAIL wrap_drain: got v=%b p=%b left=%0d want 0 0000 0", out_valid, pending, exp_q.size());
    else n_pass++;
    out_ready = 1'b0; req_in = '0;
    tick(4);
  endtask

  task automatic test_stall_drops();
    req_in = 4'b0100; exp_q.push_back(4'b0100);
    tick(4);
    n_checks++;
    if (onehot_out !== 4'b0100 || out_valid !== 1'b1) $display("FAIL stall_start: got oh=%b v=%b want 0100 1", onehot_out, out_valid);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      if (c == 2 || c == 8) req_in[2] = 1'b0;
      if (c == 5 || c == 11) req_in[2] = 1'b1;
      tick(1);
      n_checks++;
      if ({out_valid, onehot_out} !== 5'b10100) $display("FAIL stall_stable: cycle %0d got v=%b oh=%b want 1 0100", c, out_valid, onehot_out);
      else n_pass++;
    end
    n_checks++;
    if (drop_cnt !== 8'd2 || pending !== 4'b0100) $display("FAIL stall_drops: got d=%0d p=%b want 2 0100", drop_cnt, pending);
    else n_pass++;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL stall_accept: got v=%b p=%b want 0 0000", out_valid, pending);
    else n_pass++;
    req_in = '0;
    tick(4);
  endtask

  task automatic test_set_wins();
    req_in = 4'b0010; exp_q.push_back(4'b0010);
    tick(4);
    n_checks++;
    if (onehot_out !== 4'b0010 || out_valid !== 1'b1) $display("FAIL sw_first: got oh=%b v=%b want 0010 1", onehot_out, out_valid);
    else n_pass++;
    req_in = '0;
    tick(3);
    req_in = 4'b0010; exp_q.push_back(4'b0010);
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_checks++;
    if (pending !== 4'b0010 || out_valid !== 1'b0 || drop_cnt !== 8'd2)
      $display("FAIL sw_collide: got p=%b v=%b d=%0d want 0010 0 2", pending, out_valid, drop_cnt);
    else n_pass++;
    tick(1);
    n_checks++;
    if (onehot_out !== 4'b0010 || out_valid !== 1'b1) $display("FAIL sw_second: got oh=%b v=%b want 0010 1", onehot_out, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL sw_done: got v=%b p=%b want 0 0000", out_valid, pending);
    else n_pass++;
    req_in = '0;
    tick(4);
  endtask

  task automatic test_multi_drop();
    req_in = 4'b1111;
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    tick(4);
    n_checks++;
    if (onehot_out !== 4'b0100) $display("FAIL md_first: got %b want 0100", onehot_out);
    else n_pass++;
    req_in = '0;
    tick(3);
    req_in = 4'b1111;
    tick(4);
    n_checks++;
    if (drop_cnt !== 8'd6 || pending !== 4'b1111) $display("FAIL md_count: got d=%0d p=%b want 6 1111", drop_cnt, pending);
    else n_pass++;
    out_ready = 1'b1;
    tick(10);
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 4'b0000 || exp_q.size() != 0)
      $display("FAIL md_drain: got v=%b p=%b left=%0d want 0 0000 0", out_valid, pending, exp_q.size());
    else n_pass++;
    out_ready = 1'b0; req_in = '0;
    tick(4);
  endtask

  task automatic test_saturate_and_reset();
    rst2 = 1'b1; req2 = '0; ready2 = 1'b0;
    tick(2);
    rst2 = 1'b0; req2 = 4'b0001;
    tick(4);
    n_checks++;
    if (valid2 !== 1'b1 || onehot2 !== 4'b0001) $display("FAIL sat_grant: got v=%b oh=%b want 1 0001", valid2, onehot2);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      req2 = '0;
      tick(3);
      req2 = 4'b0001;
      tick(3);
      if (k == 2) begin
        n_checks++;
        if (drop2 !== 2'd2) $display("FAIL sat_mid: got %0d want 2", drop2);
        else n_pass++;
      end
    end
    n_checks++;
    if (drop2 !== 2'd3 || pending2 !== 4'b0001) $display("FAIL sat_max: got d=%0d p=%b want 3 0001", drop2, pending2);
    else n_pass++;
    rst2 = 1'b1;
    tick(1);
    n_checks++;
    if ({onehot2, valid2, pending2, drop2} !== 11'd0)
      $display("FAIL rst_mid: got oh=%b v=%b p=%b d=%0d want all 0", onehot2, valid2, pending2, drop2);
    else n_pass++;
    rst2 = 1'b0; req2 = '0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; req_in = '0; out_ready = 1'b0;
    rst2 = 1'b1; req2 = '0; ready2 = 1'b0;
    test_reset();
    test_all_four();
    test_wrap();
    test_stall_drops();
    test_set_wins();
    test_multi_drop();
    test_saturate_and_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/req_onehot_arbiter.md
Name: req_onehot_arbiter

Overview:
- Upstream stage of the 4-to-2 encoder: turns four asynchronous request lines into one one-hot 4-bit word at a time, which drives the encoder's d input.
- Each line is synchronised and rising-edge detected, then latched as a pending event.
- Pending events are granted round-robin and presented with a valid/ready handshake.
- Events that arrive while the same line is already pending are counted as drops.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per request line; legal range 1..3.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_in  in  4  asynchronous request lines; a rising edge is one event.
- onehot_out  out  4  granted request, one-hot; feeds encoder d.
- out_valid  out  1  onehot_out holds a grant.
- out_ready  in  1  consumer accepts the grant.
- pending  out  4  latched, not-yet-acknowledged events.
- drop_cnt  out  CNT_W  saturating count of lost events.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst is synchronous and active-high.
  - On rst, all of these clear to 0: sync flops, edge-history register, pending, onehot_out, out_valid, drop_cnt. Round-robin pointer ptr clears to 0. FSM returns to IDLE.
  - rst mid-handshake discards the current grant and all pending events.
- Edge detection:
  - The last sync stage output is s[i]; prev[i] is s[i] registered.
  - rise[i] = s[i] & ~prev[i].
  - A line held high through reset release produces one event, because prev resets to 0.
- Pending update, per bit, each cycle:
  - clr[i] is the handshake-complete clear for bit i.
  - Next pending[i] = rise[i] | (pending[i] & ~clr[i]).
  - If rise and clear hit the same bit in the same cycle, set wins. The new event stays pending and is not a drop.
- Drop counter:
  - drop_cnt increments when rise[i] occurs with pending[i]=1 and clr[i]=0.
  - If several such bits occur in one cycle, it increments by the number of those bits.
  - It saturates at 2^CNT_W-1.
- FSM states: IDLE and PRESENT.
  - IDLE, pending==0: stay in IDLE; out_valid=0, onehot_out=0.
  - IDLE, pending!=0: pick the first set bit scanning from ptr upward, modulo 4. Register onehot_out to that bit, set out_valid=1, go to PRESENT.
  - Bits that rise in the same cycle they are evaluated are not visible until the next cycle.
  - PRESENT: onehot_out and out_valid stay stable until out_ready=1.
  - On the cycle where out_valid & out_ready: clr of the granted bit asserts, ptr becomes granted index + 1 (mod 4), out_valid falls and onehot_out goes to 0 next cycle, FSM returns to IDLE.
  - Throughput is at most one grant per 2 cycles.
- Invariants:
  - onehot_out is always 0 or exactly one bit set.
  - Every onehot_out value is a legal one-hot encoder input.
- Latency, SYNC_STAGES=2, FSM idle:
  - req_in first sampled high at edge 1.
  - pending bit set at edge 3.
  - out_valid high after edge 4, i.e. SYNC_STAGES+2 edges.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset release with req_in=0000 -> all outputs 0, ptr=0. Then raise req_in[0] -> pending=0001 after edge 3, out_valid=1 with onehot_out=0001 after edge 4. Hold out_ready=1 -> out_valid=0 next cycle, pending=0000.
- req_in rises 0000->1111 simultaneously, out_ready held 1 -> grants 0001, 0010, 0100, 1000 in that order, one per 2 cycles, then out_valid stays 0.
- Grant 0010 accepted (ptr=2), then pending=0011 -> next grant 0001 (wrap-around), then 0010.
- out_ready held 0 for 20 cycles while onehot_out=0100 -> output stable. Toggle req_in[2] low/high twice during the stall -> drop_cnt=2, pending[2]=1 retained.
- A req_in[1] edge reaches rise[1] in the same cycle as the 0010 handshake -> pending[1] stays 1, drop_cnt unchanged, a second 0010 grant follows.
- CNT_W=2, force 5 drops -> drop_cnt saturates at 3. Assert rst while out_valid=1 -> next cycle all outputs 0.
